// File: rtl/chronos_imem_if.sv
`default_nettype none
// ============================================================================
// Module      : chronos_imem_if
// Description : Chronos instruction-fetch request/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface chronos_imem_if;
  logic [31:0] imem_req_addr;
  logic        imem_req_val;
  logic [31:0] imem_resp_data;
  logic        imem_resp_val;
  logic        imem_resp_err;

  // The core issues fetches
  modport master (
    output imem_req_addr,
    output imem_req_val,
    input  imem_resp_data,
    input  imem_resp_val,
    input  imem_resp_err
  );

  // The instruction memory answers them
  modport slave (
    input  imem_req_addr,
    input  imem_req_val,
    output imem_resp_data,
    output imem_resp_val,
    output imem_resp_err
  );
endinterface
`default_nettype wire

// File: rtl/chronos_imem.sv
`default_nettype none
// ============================================================================
// Module      : chronos_imem
// Description : Fixed-latency pipelined instruction memory with a host load
//               port and an optional post-reset NOP clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module chronos_imem #(
  parameter int          DEPTH          = 1024,
  parameter int          LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  chronos_imem_if.slave        bus,
  input  logic                 load_val,
  input  logic [31:0]          load_addr,
  input  logic [31:0]          load_data,
  output logic                 load_rdy,
  output logic [31:0]          fetch_count
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clear_idx;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_fetch_count;

  logic                r_pipe_val  [1:LATENCY];
  logic [31:0]         r_pipe_data [1:LATENCY];
  logic                r_pipe_err  [1:LATENCY];

  logic                w_ready;
  logic                w_accept;
  logic                w_fetch_bad;
  logic [ADDR_W-1:0]   w_fetch_idx;
  logic                w_load_bad;
  logic [ADDR_W-1:0]   w_load_idx;
  logic                w_load_we;

  // Misaligned, or any address bit above the word index is set
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
  endfunction

  assign w_ready     = (r_state == ST_READY);
  assign w_accept    = bus.imem_req_val && w_ready;
  assign w_fetch_bad = addr_bad(bus.imem_req_addr);
  assign w_fetch_idx = bus.imem_req_addr[ADDR_W+1:2];
  assign w_load_bad  = addr_bad(load_addr);
  assign w_load_idx  = load_addr[ADDR_W+1:2];
  assign w_load_we   = load_val && w_ready && !w_load_bad;

  assign load_rdy    = w_ready;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      r_clear_idx <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clear_idx <= r_clear_idx + 1'b1;
          if (r_clear_idx == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_READY;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Array has no reset so its contents can survive when clearing is disabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clear_idx] <= NOP_WORD;
      end else if (w_load_we) begin
        r_mem[w_load_idx] <= load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // Stage 1 reads the array; the non-blocking write above makes a same-cycle
  // load to the fetched word invisible until the next fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_val[1]  <= 1'b0;
      r_pipe_data[1] <= NOP_WORD;
      r_pipe_err[1]  <= 1'b0;
    end else begin
      r_pipe_val[1] <= w_accept;
      if (w_accept) begin
        r_pipe_err[1] <= w_fetch_bad;
        if (w_fetch_bad) begin
          r_pipe_data[1] <= NOP_WORD;
        end else begin
          r_pipe_data[1] <= r_mem[w_fetch_idx];
        end
      end
    end
  end

  generate
    for (genvar i = 2; i <= LATENCY; i++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe_val[i]  <= 1'b0;
          r_pipe_data[i] <= NOP_WORD;
          r_pipe_err[i]  <= 1'b0;
        end else begin
          r_pipe_val[i] <= r_pipe_val[i-1];
          if (r_pipe_val[i-1]) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
            r_pipe_err[i]  <= r_pipe_err[i-1];
          end
        end
      end
    end
  endgenerate

  assign bus.imem_resp_val  = r_pipe_val[LATENCY];
  assign bus.imem_resp_data = r_pipe_data[LATENCY];
  assign bus.imem_resp_err  = r_pipe_err[LATENCY];

endmodule
`default_nettype wire

// File: tb/tb_chronos_imem.sv
`default_nettype none
// ============================================================================
// Module      : tb_chronos_imem
// Description : Directed self-checking bench for chronos_imem (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chronos_imem;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic        load_val_a, load_val_b, load_val_c;
  logic [31:0] load_addr_a, load_addr_b, load_addr_c;
  logic [31:0] load_data_a, load_data_b, load_data_c;
  logic        load_rdy_a, load_rdy_b, load_rdy_c;
  logic [31:0] count_a, count_b, count_c;

  int n_pass;
  int n_total;

  chronos_imem_if ifa ();
  chronos_imem_if ifb ();
  chronos_imem_if ifc ();

  chronos_imem #(.DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa),
    .load_val(load_val_a), .load_addr(load_addr_a), .load_data(load_data_a),
    .load_rdy(load_rdy_a), .fetch_count(count_a)
  );

  chronos_imem #(.DEPTH(16), .LATENCY(3), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb),
    .load_val(load_val_b), .load_addr(load_addr_b), .load_data(load_data_b),
    .load_rdy(load_rdy_b), .fetch_count(count_b)
  );

  chronos_imem #(.DEPTH(16), .LATENCY(2), .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk(clk), .rst(rst_c), .bus(ifc),
    .load_val(load_val_c), .load_addr(load_addr_c), .load_data(load_data_c),
    .load_rdy(load_rdy_c), .fetch_count(count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] stream_exp [4];
    stream_exp[0] = 32'h1111_1111;
    stream_exp[1] = 32'h2222_2222;
    stream_exp[2] = 32'h3333_3333;
    stream_exp[3] = 32'h4444_4444;
    n_pass = 0;
    n_total = 0;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    load_val_a = 1'b0; load_addr_a = '0; load_data_a = '0;
    load_val_b = 1'b0; load_addr_b = '0; load_data_b = '0;
    load_val_c = 1'b0; load_addr_c = '0; load_data_c = '0;
    ifa.imem_req_val = 1'b0; ifa.imem_req_addr = '0;
    ifb.imem_req_val = 1'b0; ifb.imem_req_addr = '0;
    ifc.imem_req_val = 1'b0; ifc.imem_req_addr = '0;

    repeat (2) @(negedge clk);
    check("a_rst_val",   32'(ifa.imem_resp_val), 32'd0);
    check("a_rst_data",  ifa.imem_resp_data, NOP);
    check("a_rst_err",   32'(ifa.imem_resp_err), 32'd0);
    check("a_rst_count", count_a, 32'd0);
    check("a_rst_rdy",   32'(load_rdy_a), 32'd0);

    // ---- clear then fetch (DUT A) ----
    rst_a = 1'b0;
    ifa.imem_req_val = 1'b1;
    ifa.imem_req_addr = 32'h0;
    repeat (15) @(negedge clk);
    check("a_clear_rdy15",   32'(load_rdy_a), 32'd0);
    check("a_clear_noresp",  32'(ifa.imem_resp_val), 32'd0);
    @(negedge clk);
    check("a_clear_rdy16",   32'(load_rdy_a), 32'd1);
    check("a_clear_count16", count_a, 32'd0);
    @(negedge clk);
    check("a_first_val",   32'(ifa.imem_resp_val), 32'd1);
    check("a_first_data",  ifa.imem_resp_data, NOP);
    check("a_first_err",   32'(ifa.imem_resp_err), 32'd0);
    check("a_first_count", count_a, 32'd1);
    ifa.imem_req_val = 1'b0;

    // ---- loads, including one to an out-of-range address ----
    load_val_a = 1'b1; load_addr_a = 32'h00; load_data_a = 32'h1234_5678;
    @(negedge clk);
    load_addr_a = 32'h14; load_data_a = 32'hAAAA_0001;
    @(negedge clk);
    load_addr_a = 32'h40; load_data_a = 32'hDEAD_BEEF;
    @(negedge clk);
    load_val_a = 1'b0;

    // ---- bad fetch addresses ----
    ifa.imem_req_val = 1'b1; ifa.imem_req_addr = 32'h2;
    @(negedge clk);
    check("a_mis_val",  32'(ifa.imem_resp_val), 32'd1);
    check("a_mis_err",  32'(ifa.imem_resp_err), 32'd1);
    check("a_mis_data", ifa.imem_resp_data, NOP);
    ifa.imem_req_addr = 32'h40;
    @(negedge clk);
    check("a_oor_err",  32'(ifa.imem_resp_err), 32'd1);
    check("a_oor_data", ifa.imem_resp_data, NOP);
    ifa.imem_req_addr = 32'h0;
    @(negedge clk);
    check("a_word0_data", ifa.imem_resp_data, 32'h1234_5678);
    check("a_word0_err",  32'(ifa.imem_resp_err), 32'd0);

    // ---- same-cycle collision on word 5 ----
    load_val_a = 1'b1; load_addr_a = 32'h14; load_data_a = 32'hBBBB_0002;
    ifa.imem_req_addr = 32'h14;
    @(negedge clk);
    check("a_coll_old", ifa.imem_resp_data, 32'hAAAA_0001);
    load_val_a = 1'b0;
    @(negedge clk);
    check("a_coll_new", ifa.imem_resp_data, 32'hBBBB_0002);
    ifa.imem_req_val = 1'b0;
    @(negedge clk);
    check("a_idle_val",  32'(ifa.imem_resp_val), 32'd0);
    check("a_idle_hold", ifa.imem_resp_data, 32'hBBBB_0002);
    check("a_count6",    count_a, 32'd6);

    // ---- counter wrap ----
    force dut_a.r_fetch_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.r_fetch_count;
    check("a_count_max", count_a, 32'hFFFF_FFFF);
    ifa.imem_req_val = 1'b1; ifa.imem_req_addr = 32'h0;
    @(negedge clk);
    ifa.imem_req_val = 1'b0;
    check("a_count_wrap", count_a, 32'h0);

    // ---- pipelined stream, LATENCY=3 (DUT B) ----
    rst_b = 1'b0;
    for (int w = 0; w < 4; w++) begin
      load_val_b = 1'b1;
      load_addr_b = 32'(w * 4);
      load_data_b = stream_exp[w];
      @(negedge clk);
    end
    load_val_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ifb.imem_req_val  = (c < 4);
      ifb.imem_req_addr = (c < 4) ? 32'(c * 4) : 32'h0;
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        check($sformatf("b_stream_val%0d", c), 32'(ifb.imem_resp_val), 32'd1);
        check($sformatf("b_stream_data%0d", c), ifb.imem_resp_data, stream_exp[c-2]);
      end else begin
        check($sformatf("b_stream_idle%0d", c), 32'(ifb.imem_resp_val), 32'd0);
      end
    end
    check("b_count4", count_b, 32'd4);

    // ---- reset mid-stream, LATENCY=2, contents kept (DUT C) ----
    rst_c = 1'b0;
    load_val_c = 1'b1; load_addr_c = 32'h8; load_data_c = 32'hCAFE_F00D;
    @(negedge clk);
    load_val_c = 1'b0;
    ifc.imem_req_val = 1'b1; ifc.imem_req_addr = 32'h8;
    @(negedge clk);
    check("c_pre_val", 32'(ifc.imem_resp_val), 32'd0);
    rst_c = 1'b1;
    @(negedge clk);
    check("c_rst_val",   32'(ifc.imem_resp_val), 32'd0);
    check("c_rst_count", count_c, 32'd0);
    check("c_rst_data",  ifc.imem_resp_data, NOP);
    rst_c = 1'b0;
    @(negedge clk);
    check("c_post_val", 32'(ifc.imem_resp_val), 32'd0);
    check("c_post_rdy", 32'(load_rdy_c), 32'd1);
    ifc.imem_req_val = 1'b0;
    @(negedge clk);
    check("c_keep_val",   32'(ifc.imem_resp_val), 32'd1);
    check("c_keep_data",  ifc.imem_resp_data, 32'hCAFE_F00D);
    check("c_keep_err",   32'(ifc.imem_resp_err), 32'd0);
    check("c_keep_count", count_c, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
